// File: rtl/axi4_burst_addr_gen.sv
// Expands one AXI4 address-channel request into per-beat address, strobe, index and last flag.
// Illegal requests are rejected with a one-cycle error pulse instead of producing beats.
module axi4_burst_addr_gen #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int ID_WIDTH       = 4,
  parameter int BOUNDARY_BYTES = 4096
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [7:0]               req_len,
  input  logic [2:0]               req_size,
  input  logic [1:0]               req_burst,
  input  logic [ID_WIDTH-1:0]      req_id,
  output logic                     beat_valid,
  input  logic                     beat_ready,
  output logic [ADDRESS_WIDTH-1:0] beat_addr,
  output logic [DATA_WIDTH/8-1:0]  beat_strb,
  output logic [7:0]               beat_idx,
  output logic                     beat_last,
  output logic [ID_WIDTH-1:0]      beat_id,
  output logic                     err_valid,
  output logic [2:0]               err_code
);

  localparam int NB      = DATA_WIDTH / 8;
  localparam int LOG_NB  = $clog2(NB);
  localparam int LOG_BND = $clog2(BOUNDARY_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] NB_MASK = ADDRESS_WIDTH'(NB - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ONE     = ADDRESS_WIDTH'(1);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state;
  logic [7:0]               len_r;
  logic [1:0]               burst_r;
  logic [ADDRESS_WIDTH-1:0] bytes_r;
  logic [ADDRESS_WIDTH-1:0] wrap_base_r;
  logic [ADDRESS_WIDTH-1:0] wrap_end_r;

  logic [ADDRESS_WIDTH-1:0] req_bytes;
  logic [ADDRESS_WIDTH-1:0] req_align;
  logic [ADDRESS_WIDTH-1:0] req_span;
  logic [ADDRESS_WIDTH-1:0] incr_end;
  logic [ADDRESS_WIDTH-1:0] wrap_base;
  logic [2:0]               check_code;
  logic [ADDRESS_WIDTH-1:0] wrap_step;
  logic [ADDRESS_WIDTH-1:0] next_addr;
  logic [NB-1:0]            next_strb;

  // Lanes from the address offset up to the end of the size-aligned beat.
  function automatic logic [NB-1:0] lane_mask(input logic [ADDRESS_WIDTH-1:0] a,
                                              input logic [ADDRESS_WIDTH-1:0] nbytes);
    logic [ADDRESS_WIDTH-1:0] lo;
    logic [ADDRESS_WIDTH-1:0] hi;
    lane_mask = '0;
    lo = a & NB_MASK;
    hi = ((a & ~(nbytes - ONE)) & NB_MASK) + nbytes - ONE;
    for (int k = 0; k < NB; k++)
      lane_mask[k] = (ADDRESS_WIDTH'(k) >= lo) && (ADDRESS_WIDTH'(k) <= hi);
  endfunction

  always_comb begin
    req_bytes  = ONE << req_size;
    req_align  = req_addr & ~(req_bytes - ONE);
    req_span   = ADDRESS_WIDTH'({1'b0, req_len} + 9'd1) << req_size;
    incr_end   = req_align + req_span - ONE;
    wrap_base  = req_addr & ~(req_span - ONE);
    check_code = 3'd0;
    if (int'(req_size) > LOG_NB)
      check_code = 3'd1;
    else if (req_burst == 2'b11)
      check_code = 3'd2;
    else if (req_burst == BURST_WRAP && !(req_len == 8'd1 || req_len == 8'd3 ||
                                          req_len == 8'd7 || req_len == 8'd15))
      check_code = 3'd3;
    else if (req_burst == BURST_WRAP && (req_addr & (req_bytes - ONE)) != '0)
      check_code = 3'd4;
    else if (req_burst == BURST_INCR && (incr_end >> LOG_BND) != (req_addr >> LOG_BND))
      check_code = 3'd5;
    else if (req_burst == BURST_FIXED && req_len > 8'd15)
      check_code = 3'd6;
  end

  // Address and strobe of the beat that follows the one currently presented.
  always_comb begin
    wrap_step = beat_addr + bytes_r;
    case (burst_r)
      BURST_INCR: next_addr = (beat_addr & ~(bytes_r - ONE)) + bytes_r;
      BURST_WRAP: next_addr = (wrap_step == wrap_end_r) ? wrap_base_r : wrap_step;
      default:    next_addr = beat_addr;
    endcase
    next_strb = (burst_r == BURST_FIXED) ? beat_strb : lane_mask(next_addr, bytes_r);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      beat_valid  <= 1'b0;
      beat_addr   <= '0;
      beat_strb   <= '0;
      beat_idx    <= '0;
      beat_last   <= 1'b0;
      beat_id     <= '0;
      err_valid   <= 1'b0;
      err_code    <= '0;
      len_r       <= '0;
      burst_r     <= '0;
      bytes_r     <= '0;
      wrap_base_r <= '0;
      wrap_end_r  <= '0;
    end else begin
      err_valid <= 1'b0;
      err_code  <= '0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            if (check_code != 3'd0) begin
              err_valid <= 1'b1;
              err_code  <= check_code;
            end else begin
              state       <= BURST;
              req_ready   <= 1'b0;
              beat_valid  <= 1'b1;
              beat_addr   <= req_addr;
              beat_strb   <= lane_mask(req_addr, req_bytes);
              beat_idx    <= 8'd0;
              beat_last   <= (req_len == 8'd0);
              beat_id     <= req_id;
              len_r       <= req_len;
              burst_r     <= req_burst;
              bytes_r     <= req_bytes;
              wrap_base_r <= wrap_base;
              wrap_end_r  <= wrap_base + req_span;
            end
          end
        end
        BURST: begin
          if (beat_valid && beat_ready) begin
            if (beat_last) begin
              state      <= IDLE;
              beat_valid <= 1'b0;
              beat_last  <= 1'b0;
              req_ready  <= 1'b1;
            end else begin
              beat_addr <= next_addr;
              beat_strb <= next_strb;
              beat_idx  <= beat_idx + 8'd1;
              beat_last <= (beat_idx + 8'd1 == len_r);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Directed bench for axi4_burst_addr_gen: hand-computed beat sequences, error codes,
// backpressure hold and mid-burst reset recovery.
module tb_axi4_burst_addr_gen;

  logic        aclk;
  logic        areset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [1:0]  req_burst;
  logic [3:0]  req_id;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_addr;
  logic [7:0]  beat_strb;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic [3:0]  beat_id;
  logic        err_valid;
  logic [2:0]  err_code;

  int compare_count = 0;
  int fail_count    = 0;

  logic [31:0] exp_addr [16];
  logic [7:0]  exp_strb [16];

  axi4_burst_addr_gen #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .BOUNDARY_BYTES(4096)
  ) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size), .req_burst(req_burst), .req_id(req_id),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_strb(beat_strb), .beat_idx(beat_idx), .beat_last(beat_last), .beat_id(beat_id),
    .err_valid(err_valid), .err_code(err_code)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge aclk);
    #1;
  endtask

  // Present a request and hold it until the generator accepts it.
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [3:0] id);
    logic accepted;
    accepted  = 1'b0;
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    req_size  = size;
    req_burst = burst;
    req_id    = id;
    for (int t = 0; t < 20 && !accepted; t++) begin
      accepted = req_ready;
      stepCycle();
    end
    req_valid = 1'b0;
    checkOutput("req_accept", 64'(accepted), 64'd1);
  endtask

  // Walks a burst against exp_addr/exp_strb, optionally stalling at one beat.
  task automatic checkBurst(input string name, input int n, input int stall_idx,
                            input int stall_cycles, input logic [3:0] id);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_valid%0d", name, i), 64'(beat_valid), 64'd1);
      checkOutput($sformatf("%s_addr%0d", name, i), 64'(beat_addr), 64'(exp_addr[i]));
      checkOutput($sformatf("%s_strb%0d", name, i), 64'(beat_strb), 64'(exp_strb[i]));
      checkOutput($sformatf("%s_idx%0d", name, i), 64'(beat_idx), 64'(i));
      checkOutput($sformatf("%s_last%0d", name, i), 64'(beat_last), 64'(i == n - 1));
      checkOutput($sformatf("%s_id%0d", name, i), 64'(beat_id), 64'(id));
      checkOutput($sformatf("%s_rdy%0d", name, i), 64'(req_ready), 64'd0);
      if (i == stall_idx) begin
        beat_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          stepCycle();
          checkOutput($sformatf("%s_hold_valid%0d", name, s), 64'(beat_valid), 64'd1);
          checkOutput($sformatf("%s_hold_addr%0d", name, s), 64'(beat_addr), 64'(exp_addr[i]));
          checkOutput($sformatf("%s_hold_strb%0d", name, s), 64'(beat_strb), 64'(exp_strb[i]));
          checkOutput($sformatf("%s_hold_idx%0d", name, s), 64'(beat_idx), 64'(i));
        end
        beat_ready = 1'b1;
      end
      stepCycle();
    end
    checkOutput({name, "_done_valid"}, 64'(beat_valid), 64'd0);
    checkOutput({name, "_done_rdy"}, 64'(req_ready), 64'd1);
  endtask

  task automatic checkError(input string name, input logic [2:0] code);
    checkOutput({name, "_err_valid"}, 64'(err_valid), 64'd1);
    checkOutput({name, "_err_code"}, 64'(err_code), 64'(code));
    checkOutput({name, "_no_beat"}, 64'(beat_valid), 64'd0);
    checkOutput({name, "_rdy"}, 64'(req_ready), 64'd1);
    stepCycle();
    checkOutput({name, "_err_pulse"}, 64'(err_valid), 64'd0);
    checkOutput({name, "_no_beat2"}, 64'(beat_valid), 64'd0);
  endtask

  initial begin
    areset     = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    req_size   = '0;
    req_burst  = '0;
    req_id     = '0;
    beat_ready = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_beat_valid", 64'(beat_valid), 64'd0);
    checkOutput("rst_beat_addr", 64'(beat_addr), 64'd0);
    checkOutput("rst_beat_strb", 64'(beat_strb), 64'd0);
    checkOutput("rst_err_valid", 64'(err_valid), 64'd0);
    checkOutput("rst_err_code", 64'(err_code), 64'd0);
    areset = 1'b0;
    stepCycle();
    checkOutput("post_rst_ready", 64'(req_ready), 64'd1);

    // INCR with an unaligned start: half-lane strobes alternate.
    exp_addr[0] = 32'h1004; exp_strb[0] = 8'hF0;
    exp_addr[1] = 32'h1008; exp_strb[1] = 8'h0F;
    exp_addr[2] = 32'h100C; exp_strb[2] = 8'hF0;
    exp_addr[3] = 32'h1010; exp_strb[3] = 8'h0F;
    applyStimulus(32'h1004, 8'd3, 3'd2, 2'b01, 4'h3);
    checkBurst("incr", 4, -1, 0, 4'h3);

    exp_addr[0] = 32'h38; exp_addr[1] = 32'h20; exp_addr[2] = 32'h28; exp_addr[3] = 32'h30;
    for (int i = 0; i < 4; i++) exp_strb[i] = 8'hFF;
    applyStimulus(32'h38, 8'd3, 3'd3, 2'b10, 4'h5);
    checkBurst("wrap", 4, -1, 0, 4'h5);

    exp_addr[0] = 32'h103; exp_strb[0] = 8'h08;
    exp_addr[1] = 32'h103; exp_strb[1] = 8'h08;
    applyStimulus(32'h103, 8'd1, 3'd2, 2'b00, 4'h9);
    checkBurst("fixed", 2, -1, 0, 4'h9);

    // Single-beat bursts: byte-sized, and one ending exactly on the 4 KiB boundary.
    exp_addr[0] = 32'h41; exp_strb[0] = 8'h02;
    applyStimulus(32'h41, 8'd0, 3'd0, 2'b01, 4'h1);
    checkBurst("single", 1, -1, 0, 4'h1);
    exp_addr[0] = 32'hFF8; exp_strb[0] = 8'hFF;
    applyStimulus(32'hFF8, 8'd0, 3'd3, 2'b01, 4'h2);
    checkBurst("edge4k", 1, -1, 0, 4'h2);

    applyStimulus(32'hFF8, 8'd1, 3'd3, 2'b01, 4'h0);
    checkError("cross4k", 3'd5);
    applyStimulus(32'h0, 8'd1, 3'd4, 2'b01, 4'h0);
    checkError("size", 3'd1);
    applyStimulus(32'h0, 8'd1, 3'd2, 2'b11, 4'h0);
    checkError("rsvd", 3'd2);
    applyStimulus(32'h0, 8'd2, 3'd2, 2'b10, 4'h0);
    checkError("wraplen", 3'd3);
    applyStimulus(32'h34, 8'd3, 3'd3, 2'b10, 4'h0);
    checkError("wrapalign", 3'd4);
    applyStimulus(32'h0, 8'd16, 3'd2, 2'b00, 4'h0);
    checkError("fixedlen", 3'd6);
    applyStimulus(32'h0, 8'd2, 3'd4, 2'b11, 4'h0);
    checkError("priority", 3'd1);

    for (int i = 0; i < 8; i++) begin
      exp_addr[i] = 32'h2000 + 32'(i * 8);
      exp_strb[i] = 8'hFF;
    end
    applyStimulus(32'h2000, 8'd7, 3'd3, 2'b01, 4'hA);
    checkBurst("stall", 8, 2, 3, 4'hA);

    // Reset in the middle of a long burst, then a fresh request.
    applyStimulus(32'h0, 8'd15, 3'd3, 2'b01, 4'h7);
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("mid_idx", 64'(beat_idx), 64'd4);
    checkOutput("mid_addr", 64'(beat_addr), 64'h20);
    areset = 1'b1;
    stepCycle();
    checkOutput("mid_rst_valid", 64'(beat_valid), 64'd0);
    checkOutput("mid_rst_addr", 64'(beat_addr), 64'd0);
    checkOutput("mid_rst_strb", 64'(beat_strb), 64'd0);
    checkOutput("mid_rst_idx", 64'(beat_idx), 64'd0);
    checkOutput("mid_rst_last", 64'(beat_last), 64'd0);
    checkOutput("mid_rst_err", 64'(err_valid), 64'd0);
    checkOutput("mid_rst_rdy", 64'(req_ready), 64'd0);
    areset = 1'b0;
    stepCycle();
    checkOutput("mid_rel_rdy", 64'(req_ready), 64'd1);
    exp_addr[0] = 32'h200; exp_strb[0] = 8'hFF;
    exp_addr[1] = 32'h208; exp_strb[1] = 8'hFF;
    applyStimulus(32'h200, 8'd1, 3'd3, 2'b01, 4'hC);
    checkBurst("fresh", 2, -1, 0, 4'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
